// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer:
// state encodings, datapath mux codes, ALU codes, opcodes and halt causes.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_JALR    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } inst_class_t;

    // PC source select
    localparam logic [1:0] PC4   = 2'd0;
    localparam logic [1:0] PCBEQ = 2'd1;
    localparam logic [1:0] PCIMM = 2'd2;
    localparam logic [1:0] PCALU = 2'd3;

    // Register file write-data select
    localparam logic [1:0] ORIG_MEM = 2'd0;
    localparam logic [1:0] ORIG_ALU = 2'd1;
    localparam logic [1:0] ORIG_PC4 = 2'd2;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Opcodes
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // Halt causes
    localparam logic [1:0] HALT_NONE      = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL   = 2'd1;
    localparam logic [1:0] HALT_FETCH_TMO = 2'd2;
    localparam logic [1:0] HALT_DATA_TMO  = 2'd3;

    // Maps funct3 to an ALU code; alt selects SUB for 000 and SRA for 101.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] code;
        code = ALU_ADD;
        case (funct3)
            3'b000: code = alt ? ALU_SUB : ALU_ADD;
            3'b001: code = ALU_SLL;
            3'b010: code = ALU_SLT;
            3'b011: code = ALU_SLTU;
            3'b100: code = ALU_XOR;
            3'b101: code = alt ? ALU_SRA : ALU_SRL;
            3'b110: code = ALU_OR;
            3'b111: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the sequencer, the datapath and the
// instruction/data memories. master = sequencer side.
interface multicycle_sequencer_if;

    logic [31:0] instruction;
    logic        branchEqual;
    logic        iMemReady;
    logic        dMemReady;
    logic        iMemRead;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  OrigPC;
    logic [1:0]  OrigWriteData;
    logic        OrigULA;
    logic [3:0]  ALUControl;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        halted;
    logic [1:0]  haltCause;
    logic [2:0]  state;

    modport master (
        input  instruction, branchEqual, iMemReady, dMemReady,
        output iMemRead, IRWrite, PCWrite, OrigPC, OrigWriteData, OrigULA,
               ALUControl, MemRead, MemWrite, RegWrite, halted, haltCause, state
    );

    modport slave (
        output instruction, branchEqual, iMemReady, dMemReady,
        input  iMemRead, IRWrite, PCWrite, OrigPC, OrigWriteData, OrigULA,
               ALUControl, MemRead, MemWrite, RegWrite, halted, haltCause, state
    );

endinterface

// File: rtl/multicycle_sequencer_decode.sv
// Combinational instruction decoder: classifies the IR word, picks the ALU
// operation and operand-B source, and flags unsupported encodings.
module multicycle_sequencer_decode
    import multicycle_sequencer_pkg::*;
(
    input  logic [31:0] instruction,
    output inst_class_t inst_class,
    output logic [3:0]  alu_control,
    output logic        use_imm,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7_b5     = instruction[30];
    assign unused_fields = &{1'b0, instruction[31], instruction[29:15], instruction[11:7]};

    // Opcode/funct3 classification; I-ALU only honours funct7[5] for SRAI
    always_comb begin
        inst_class  = CLS_ILLEGAL;
        alu_control = ALU_ADD;
        use_imm     = 1'b0;
        case (opcode)
            OP_R: begin
                inst_class  = CLS_R;
                alu_control = alu_from_funct3(funct3, funct7_b5);
            end
            OP_I: begin
                inst_class  = CLS_I;
                use_imm     = 1'b1;
                alu_control = alu_from_funct3(funct3, funct7_b5 && (funct3 == 3'b101));
            end
            OP_LW: begin
                if (funct3 == F3_WORD) begin
                    inst_class = CLS_LW;
                    use_imm    = 1'b1;
                end
            end
            OP_SW: begin
                if (funct3 == F3_WORD) begin
                    inst_class = CLS_SW;
                    use_imm    = 1'b1;
                end
            end
            OP_BEQ: begin
                if (funct3 == F3_BEQ) begin
                    inst_class  = CLS_BEQ;
                    alu_control = ALU_SUB;
                end
            end
            OP_JAL: begin
                inst_class = CLS_JAL;
            end
            OP_JALR: begin
                inst_class = CLS_JALR;
                use_imm    = 1'b1;
            end
            default: begin
                inst_class = CLS_ILLEGAL;
            end
        endcase
    end

    assign legal = (inst_class != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the single-issue RISC-V datapath:
// RESET -> FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK] -> FETCH,
// with memory-ready timeouts and illegal-opcode detection leading to HALT.
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 16,
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clock,
    input  logic        resetn,
`ifdef MULTICYCLE_PERF_EN
    output logic [31:0] cycleCount,
    output logic [31:0] instretCount,
`endif
    multicycle_sequencer_if.master bus
);

    state_t      cur_state, next_state;
    logic [7:0]  wait_count, next_wait;
    logic [2:0]  hold_count, next_hold;
    logic [1:0]  halt_cause, next_cause;

    inst_class_t dec_class;
    logic [3:0]  dec_alu;
    logic        dec_imm;
    logic        dec_legal;
    logic        rd_is_zero;
    logic        unused_branch;

    logic        i_mem_read, ir_write, pc_write, mem_read, mem_write, reg_write;
    logic [1:0]  orig_pc, orig_write_data;
    logic        orig_ula;
    logic [3:0]  alu_control;

    multicycle_sequencer_decode u_decode (
        .instruction (bus.instruction),
        .inst_class  (dec_class),
        .alu_control (dec_alu),
        .use_imm     (dec_imm),
        .legal       (dec_legal)
    );

    assign rd_is_zero    = (bus.instruction[11:7] == 5'd0);
    assign unused_branch = bus.branchEqual;

    // State, wait/hold counters and latched halt cause
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur_state  <= ST_RESET;
            wait_count <= '0;
            hold_count <= '0;
            halt_cause <= HALT_NONE;
        end else begin
            cur_state  <= next_state;
            wait_count <= next_wait;
            hold_count <= next_hold;
            halt_cause <= next_cause;
        end
    end

    // Next-state and control decode; IRWrite and the SW PC update follow ready directly
    always_comb begin
        next_state      = cur_state;
        next_wait       = wait_count;
        next_hold       = hold_count;
        next_cause      = halt_cause;
        i_mem_read      = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        reg_write       = 1'b0;
        orig_pc         = PC4;
        orig_write_data = ORIG_MEM;
        orig_ula        = 1'b0;
        alu_control     = ALU_ADD;
        case (cur_state)
            ST_RESET: begin
                if (hold_count >= 3'(RESET_PC_HOLD)) begin
                    next_state = ST_FETCH;
                end else begin
                    next_hold = hold_count + 3'd1;
                end
            end
            ST_FETCH: begin
                i_mem_read = 1'b1;
                if (bus.iMemReady) begin
                    ir_write   = 1'b1;
                    next_state = ST_DECODE;
                end else if (wait_count == 8'(MEM_TIMEOUT - 1)) begin
                    next_state = ST_HALT;
                    next_cause = HALT_FETCH_TMO;
                end else begin
                    next_wait = wait_count + 8'd1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    next_state = ST_EXECUTE;
                end else begin
                    next_state = ST_HALT;
                    next_cause = HALT_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                alu_control = dec_alu;
                orig_ula    = dec_imm;
                case (dec_class)
                    CLS_LW, CLS_SW: next_state = ST_MEM;
                    CLS_BEQ: begin
                        pc_write   = 1'b1;
                        orig_pc    = PCBEQ;
                        next_state = ST_FETCH;
                    end
                    default: next_state = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                alu_control = dec_alu;
                orig_ula    = dec_imm;
                if (dec_class == CLS_LW) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (bus.dMemReady) begin
                    if (dec_class == CLS_LW) begin
                        next_state = ST_WRITEBACK;
                    end else begin
                        pc_write   = 1'b1;
                        orig_pc    = PC4;
                        next_state = ST_FETCH;
                    end
                end else if (wait_count == 8'(MEM_TIMEOUT - 1)) begin
                    next_state = ST_HALT;
                    next_cause = HALT_DATA_TMO;
                end else begin
                    next_wait = wait_count + 8'd1;
                end
            end
            ST_WRITEBACK: begin
                alu_control = dec_alu;
                orig_ula    = dec_imm;
                reg_write   = !rd_is_zero;
                pc_write    = 1'b1;
                next_state  = ST_FETCH;
                case (dec_class)
                    CLS_LW: begin
                        orig_write_data = ORIG_MEM;
                        orig_pc         = PC4;
                    end
                    CLS_JAL: begin
                        orig_write_data = ORIG_PC4;
                        orig_pc         = PCIMM;
                    end
                    CLS_JALR: begin
                        orig_write_data = ORIG_PC4;
                        orig_pc         = PCALU;
                    end
                    default: begin
                        orig_write_data = ORIG_ALU;
                        orig_pc         = PC4;
                    end
                endcase
            end
            default: begin
                next_state = ST_HALT;
            end
        endcase
        if (next_state != cur_state) begin
            next_wait = '0;
            next_hold = '0;
        end
    end

    assign bus.iMemRead      = i_mem_read;
    assign bus.IRWrite       = ir_write;
    assign bus.PCWrite       = pc_write;
    assign bus.OrigPC        = orig_pc;
    assign bus.OrigWriteData = orig_write_data;
    assign bus.OrigULA       = orig_ula;
    assign bus.ALUControl    = alu_control;
    assign bus.MemRead       = mem_read;
    assign bus.MemWrite      = mem_write;
    assign bus.RegWrite      = reg_write;
    assign bus.halted        = (cur_state == ST_HALT);
    assign bus.haltCause     = halt_cause;
    assign bus.state         = cur_state;

`ifdef MULTICYCLE_PERF_EN
    logic retire;

    assign retire = (next_state == ST_FETCH) &&
                    ((cur_state == ST_EXECUTE) || (cur_state == ST_MEM) || (cur_state == ST_WRITEBACK));

    // Active-cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cycleCount   <= '0;
            instretCount <= '0;
        end else begin
            if ((cur_state != ST_RESET) && (cur_state != ST_HALT)) begin
                cycleCount <= cycleCount + 32'd1;
            end
            if (retire) begin
                instretCount <= instretCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer (MEM_TIMEOUT=16, RESET_PC_HOLD=1).
// Counter checks are included when MULTICYCLE_PERF_EN is defined.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    int   total = 0;
    int   bad = 0;

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
`endif

    multicycle_sequencer_if bus ();

    multicycle_sequencer #(.MEM_TIMEOUT(16), .RESET_PC_HOLD(1)) dut (
        .clock        (clock),
        .resetn       (resetn),
`ifdef MULTICYCLE_PERF_EN
        .cycleCount   (cycle_count),
        .instretCount (instret_count),
`endif
        .bus          (bus)
    );

    always #5 clock = ~clock;

    // {iMemRead, IRWrite, PCWrite, MemRead, MemWrite, RegWrite}
    logic [5:0] strobes;
    assign strobes = {bus.iMemRead, bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite, bus.RegWrite};

    localparam logic [5:0] SB_NONE  = 6'b000000;
    localparam logic [5:0] SB_FWAIT = 6'b100000;
    localparam logic [5:0] SB_FRDY  = 6'b110000;
    localparam logic [5:0] SB_WB    = 6'b001001;
    localparam logic [5:0] SB_WBX0  = 6'b001000;
    localparam logic [5:0] SB_BEQ   = 6'b001000;
    localparam logic [5:0] SB_LWM   = 6'b000100;
    localparam logic [5:0] SB_SWM   = 6'b000010;
    localparam logic [5:0] SB_SWRDY = 6'b001010;

    // Pulse reset and return at the last RESET-hold cycle; the next negedge is FETCH cycle 1
    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        bus.iMemReady   = 1'b1;
        bus.dMemReady   = 1'b1;
        bus.branchEqual = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.instruction = 32'h002081B3;
        bus.iMemReady   = 1'b1;
        bus.dMemReady   = 1'b1;
        bus.branchEqual = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        total++;
        if (bus.state !== ST_RESET) begin bad++; $display("[TB] FAIL reset_state got=%0d want=%0d", bus.state, ST_RESET); end
        total++;
        if ({strobes, bus.OrigPC, bus.OrigWriteData, bus.OrigULA, bus.ALUControl} !== 15'd0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%b want=0", {strobes, bus.OrigPC, bus.OrigWriteData, bus.OrigULA, bus.ALUControl});
        end
        total++;
        if ({bus.halted, bus.haltCause} !== 3'd0) begin bad++; $display("[TB] FAIL reset_halt got=%b want=000", {bus.halted, bus.haltCause}); end
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        total++;
        if (bus.state !== ST_RESET) begin bad++; $display("[TB] FAIL reset_hold got=%0d want=%0d", bus.state, ST_RESET); end
        @(negedge clock);
        #1;
        total++;
        if (bus.state !== ST_FETCH) begin bad++; $display("[TB] FAIL reset_to_fetch got=%0d want=%0d", bus.state, ST_FETCH); end
    endtask

    task automatic test_add();
        logic [2:0] es [5] = '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_FETCH};
        logic [5:0] eb [5] = '{SB_FRDY, SB_NONE, SB_NONE, SB_WB, SB_FRDY};
        do_reset();
        bus.instruction = 32'h002081B3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            total++;
            if (bus.state !== es[c]) begin bad++; $display("[TB] FAIL add_state c%0d got=%0d want=%0d", c, bus.state, es[c]); end
            total++;
            if (strobes !== eb[c]) begin bad++; $display("[TB] FAIL add_strobes c%0d got=%b want=%b", c, strobes, eb[c]); end
            if (c == 2) begin
                total++;
                if ({bus.ALUControl, bus.OrigULA} !== {ALU_ADD, 1'b0}) begin bad++; $display("[TB] FAIL add_exec_alu got=%b want=%b", {bus.ALUControl, bus.OrigULA}, {ALU_ADD, 1'b0}); end
            end
            if (c == 3) begin
                total++;
                if ({bus.OrigWriteData, bus.OrigPC} !== {ORIG_ALU, PC4}) begin bad++; $display("[TB] FAIL add_wb_sel got=%b want=%b", {bus.OrigWriteData, bus.OrigPC}, {ORIG_ALU, PC4}); end
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [2:0] es [9] = '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_MEM, ST_MEM, ST_MEM, ST_WRITEBACK, ST_FETCH};
        logic [5:0] eb [9] = '{SB_FRDY, SB_NONE, SB_NONE, SB_LWM, SB_LWM, SB_LWM, SB_LWM, SB_WB, SB_FRDY};
        int reads = 0;
        do_reset();
        bus.instruction = 32'h0080A283;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            bus.dMemReady = (c == 6);
            #1;
            if (bus.MemRead === 1'b1) reads++;
            total++;
            if (bus.state !== es[c]) begin bad++; $display("[TB] FAIL lw_state c%0d got=%0d want=%0d", c, bus.state, es[c]); end
            total++;
            if (strobes !== eb[c]) begin bad++; $display("[TB] FAIL lw_strobes c%0d got=%b want=%b", c, strobes, eb[c]); end
            if (c == 2) begin
                total++;
                if ({bus.ALUControl, bus.OrigULA} !== {ALU_ADD, 1'b1}) begin bad++; $display("[TB] FAIL lw_exec_alu got=%b want=%b", {bus.ALUControl, bus.OrigULA}, {ALU_ADD, 1'b1}); end
            end
            if (c == 7) begin
                total++;
                if ({bus.OrigWriteData, bus.OrigPC} !== {ORIG_MEM, PC4}) begin bad++; $display("[TB] FAIL lw_wb_sel got=%b want=%b", {bus.OrigWriteData, bus.OrigPC}, {ORIG_MEM, PC4}); end
            end
        end
        total++;
        if (reads != 4) begin bad++; $display("[TB] FAIL lw_memread_cycles got=%0d want=4", reads); end
        bus.dMemReady = 1'b1;
    endtask

    task automatic test_beq();
        logic [2:0] es [4] = '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_FETCH};
        logic [5:0] eb [4] = '{SB_FRDY, SB_NONE, SB_BEQ, SB_FRDY};
        do_reset();
        bus.instruction = 32'h00208463;
        bus.branchEqual = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            total++;
            if (bus.state !== es[c]) begin bad++; $display("[TB] FAIL beq_state c%0d got=%0d want=%0d", c, bus.state, es[c]); end
            total++;
            if (strobes !== eb[c]) begin bad++; $display("[TB] FAIL beq_strobes c%0d got=%b want=%b", c, strobes, eb[c]); end
            if (c == 2) begin
                total++;
                if ({bus.OrigPC, bus.ALUControl} !== {PCBEQ, ALU_SUB}) begin bad++; $display("[TB] FAIL beq_exec_sel got=%b want=%b", {bus.OrigPC, bus.ALUControl}, {PCBEQ, ALU_SUB}); end
            end
        end
        bus.branchEqual = 1'b0;
    endtask

    task automatic test_sw();
        logic [2:0] es [5] = '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_FETCH};
        logic [5:0] eb [5] = '{SB_FRDY, SB_NONE, SB_NONE, SB_SWRDY, SB_FRDY};
        do_reset();
        bus.instruction = 32'h0020A223;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            total++;
            if (bus.state !== es[c]) begin bad++; $display("[TB] FAIL sw_state c%0d got=%0d want=%0d", c, bus.state, es[c]); end
            total++;
            if (strobes !== eb[c]) begin bad++; $display("[TB] FAIL sw_strobes c%0d got=%b want=%b", c, strobes, eb[c]); end
            if (c == 3) begin
                total++;
                if ({bus.OrigPC, bus.OrigULA, bus.ALUControl} !== {PC4, 1'b1, ALU_ADD}) begin bad++; $display("[TB] FAIL sw_mem_sel got=%b want=%b", {bus.OrigPC, bus.OrigULA, bus.ALUControl}, {PC4, 1'b1, ALU_ADD}); end
            end
        end
    endtask

    task automatic test_jumps();
        logic [31:0] ins [2] = '{32'h010000EF, 32'h000100E7};
        logic [1:0]  epc [2] = '{PCIMM, PCALU};
        logic        eimm [2] = '{1'b0, 1'b1};
        for (int j = 0; j < 2; j++) begin
            do_reset();
            bus.instruction = ins[j];
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                #1;
                if (c == 3) begin
                    total++;
                    if (strobes !== SB_WB) begin bad++; $display("[TB] FAIL jump%0d_wb_strobes got=%b want=%b", j, strobes, SB_WB); end
                    total++;
                    if ({bus.OrigWriteData, bus.OrigPC, bus.OrigULA, bus.ALUControl} !== {ORIG_PC4, epc[j], eimm[j], ALU_ADD}) begin
                        bad++; $display("[TB] FAIL jump%0d_wb_sel got=%b want=%b", j, {bus.OrigWriteData, bus.OrigPC, bus.OrigULA, bus.ALUControl}, {ORIG_PC4, epc[j], eimm[j], ALU_ADD});
                    end
                end
                if (c == 4) begin
                    total++;
                    if (bus.state !== ST_FETCH) begin bad++; $display("[TB] FAIL jump%0d_refetch got=%0d want=%0d", j, bus.state, ST_FETCH); end
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2] = '{32'h0000007F, 32'h00008283};
        for (int j = 0; j < 2; j++) begin
            do_reset();
            bus.instruction = ins[j];
            for (int c = 0; c < 8; c++) begin
                @(negedge clock);
                #1;
                if (c >= 2) begin
                    total++;
                    if ({bus.state, bus.halted, bus.haltCause} !== {ST_HALT, 1'b1, HALT_ILLEGAL}) begin
                        bad++; $display("[TB] FAIL illegal%0d_halt c%0d got=%b want=%b", j, c, {bus.state, bus.halted, bus.haltCause}, {ST_HALT, 1'b1, HALT_ILLEGAL});
                    end
                    total++;
                    if (strobes !== SB_NONE) begin bad++; $display("[TB] FAIL illegal%0d_strobes c%0d got=%b want=%b", j, c, strobes, SB_NONE); end
                end
            end
        end
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        bus.instruction = 32'h002081B3;
        // 15 stalled fetch cycles then ready: must not time out
        for (int c = 0; c < 17; c++) begin
            @(negedge clock);
            bus.iMemReady = (c == 15);
            #1;
            if (c == 14) begin
                total++;
                if (strobes !== SB_FWAIT) begin bad++; $display("[TB] FAIL fetch15_wait got=%b want=%b", strobes, SB_FWAIT); end
            end
            if (c == 15) begin
                total++;
                if (strobes !== SB_FRDY) begin bad++; $display("[TB] FAIL fetch15_ready got=%b want=%b", strobes, SB_FRDY); end
            end
            if (c == 16) begin
                total++;
                if (bus.state !== ST_DECODE) begin bad++; $display("[TB] FAIL fetch15_decode got=%0d want=%0d", bus.state, ST_DECODE); end
            end
        end
        @(negedge clock);
        @(negedge clock);
        // Next fetch never gets ready: 16 request cycles, then HALT
        bus.iMemReady = 1'b0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clock);
            #1;
            if (c < 16) begin
                total++;
                if ({bus.state, strobes} !== {ST_FETCH, SB_FWAIT}) begin bad++; $display("[TB] FAIL ftmo_wait c%0d got=%b want=%b", c, {bus.state, strobes}, {ST_FETCH, SB_FWAIT}); end
            end else begin
                total++;
                if ({bus.state, bus.halted, bus.haltCause, strobes} !== {ST_HALT, 1'b1, HALT_FETCH_TMO, SB_NONE}) begin
                    bad++; $display("[TB] FAIL ftmo_halt got=%b want=%b", {bus.state, bus.halted, bus.haltCause, strobes}, {ST_HALT, 1'b1, HALT_FETCH_TMO, SB_NONE});
                end
            end
        end
        bus.iMemReady = 1'b1;
    endtask

    task automatic test_data_timeout();
        do_reset();
        bus.instruction = 32'h0020A223;
        bus.dMemReady = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #1;
            if (c >= 3 && c < 19) begin
                total++;
                if ({bus.state, strobes} !== {ST_MEM, SB_SWM}) begin bad++; $display("[TB] FAIL dtmo_wait c%0d got=%b want=%b", c, {bus.state, strobes}, {ST_MEM, SB_SWM}); end
            end
            if (c == 19) begin
                total++;
                if ({bus.state, bus.halted, bus.haltCause, strobes} !== {ST_HALT, 1'b1, HALT_DATA_TMO, SB_NONE}) begin
                    bad++; $display("[TB] FAIL dtmo_halt got=%b want=%b", {bus.state, bus.halted, bus.haltCause, strobes}, {ST_HALT, 1'b1, HALT_DATA_TMO, SB_NONE});
                end
            end
        end
        bus.dMemReady = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        bus.instruction = 32'h0020A223;
        bus.dMemReady = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
        end
        total++;
        if (strobes !== SB_SWM) begin bad++; $display("[TB] FAIL midmem_before got=%b want=%b", strobes, SB_SWM); end
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({bus.state, strobes, bus.halted} !== {ST_RESET, SB_NONE, 1'b0}) begin
            bad++; $display("[TB] FAIL midmem_reset got=%b want=%b", {bus.state, strobes, bus.halted}, {ST_RESET, SB_NONE, 1'b0});
        end
        bus.dMemReady = 1'b1;
    endtask

    task automatic test_addi_x0();
        do_reset();
        bus.instruction = 32'h00500013;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            if (c == 3) begin
                total++;
                if ({bus.state, strobes, bus.OrigWriteData} !== {ST_WRITEBACK, SB_WBX0, ORIG_ALU}) begin
                    bad++; $display("[TB] FAIL x0_wb got=%b want=%b", {bus.state, strobes, bus.OrigWriteData}, {ST_WRITEBACK, SB_WBX0, ORIG_ALU});
                end
            end
`ifdef MULTICYCLE_PERF_EN
            if (c == 4) begin
                total++;
                if (cycle_count !== 32'd4) begin bad++; $display("[TB] FAIL perf_cycles got=%0d want=4", cycle_count); end
                total++;
                if (instret_count !== 32'd1) begin bad++; $display("[TB] FAIL perf_instret got=%0d want=1", instret_count); end
            end
`endif
        end
    endtask

    task automatic test_alu_decode();
        logic [31:0] ins [6] = '{32'h002081B3, 32'h402081B3, 32'h4030D213, 32'h40000013, 32'h0020B1B3, 32'h4000C213};
        logic [3:0]  alu [6] = '{ALU_ADD, ALU_SUB, ALU_SRA, ALU_ADD, ALU_SLTU, ALU_XOR};
        logic        imm [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 6; j++) begin
            do_reset();
            bus.instruction = ins[j];
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                #1;
            end
            total++;
            if ({bus.state, bus.ALUControl, bus.OrigULA} !== {ST_EXECUTE, alu[j], imm[j]}) begin
                bad++; $display("[TB] FAIL alu_dec%0d got=%b want=%b", j, {bus.state, bus.ALUControl, bus.OrigULA}, {ST_EXECUTE, alu[j], imm[j]});
            end
        end
    endtask

    initial begin
        bus.instruction = 32'h0;
        bus.iMemReady   = 1'b1;
        bus.dMemReady   = 1'b1;
        bus.branchEqual = 1'b0;
        $display("[TB] starting multicycle_sequencer bench");
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_sw();
        test_jumps();
        test_illegal();
        test_fetch_timeout();
        test_data_timeout();
        test_reset_mid_mem();
        test_addi_x0();
        test_alu_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the single-issue RISC-V datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, one instruction at a time.
- Replaces the single-cycle combinational control. It drives PC/IR write enables, mux selects and memory strobes.
- It handshakes with instruction and data memories that may take wait states.
- Sits between the datapath and both memories; the datapath keeps its muxes, ALU and register file.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for a memory ready before halting (1..255).
- RESET_PC_HOLD, 1, cycles held in RESET state after resetn deasserts before the first FETCH (0..7).

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- instruction  input  32  IR contents (valid from DECODE onward).
- branchEqual  input  1  registerRead1 == registerRead2 from the datapath.
- iMemReady  input  1  instruction memory data valid.
- dMemReady  input  1  data memory access complete.
- iMemRead  output  1  instruction fetch request.
- IRWrite  output  1  latch the fetched word into IR.
- PCWrite  output  1  update PC with the selected source.
- OrigPC  output  2  0=PC4, 1=PCBEQ, 2=PCIMM, 3=PCALU (JALR).
- OrigWriteData  output  2  0=MEM, 1=ALU, 2=PC4.
- OrigULA  output  1  0=rs2, 1=immediate.
- ALUControl  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- MemRead  output  1  data memory read strobe.
- MemWrite  output  1  data memory write strobe.
- RegWrite  output  1  register file write enable.
- halted  output  1  FSM is in HALT.
- haltCause  output  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout.
- state  output  3  current state, for debug.

Behaviour:
- **Reset.** resetn low forces the following at once (asynchronous): state=RESET, wait counter=0, every control output 0, halted=0, haltCause=0.
- **RESET.** Holds for RESET_PC_HOLD cycles, then goes to FETCH. If RESET_PC_HOLD=0, the next edge goes to FETCH.
- **FETCH.**
  - iMemRead=1 continuously until iMemReady.
  - In the cycle iMemReady=1: IRWrite=1, then go to DECODE.
  - The wait counter increments each cycle without ready. On reaching MEM_TIMEOUT: go to HALT with cause 2.
- **DECODE.** One cycle with all strobes 0. Legal opcodes are:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 LW (funct3 010)
  - 0100011 SW (funct3 010)
  - 1100011 BEQ (funct3 000)
  - 1101111 JAL
  - 1100111 JALR
  - Anything else, including unsupported funct3, goes to HALT with cause 1.
- **EXECUTE.** ALUControl is decoded from funct3/funct7: funct7[5] selects SUB/SRA; I-ALU ignores funct7[5] except for SRAI. OrigULA=1 for I-ALU, LW, SW and JALR. Per instruction:
  - R / I-ALU: go to WRITEBACK.
  - LW / SW: ALU=ADD, go to MEM.
  - BEQ: ALU=SUB, PCWrite=1, OrigPC=1 (datapath applies branchEqual), go to FETCH.
  - JAL / JALR: go to WRITEBACK.
- **MEM.**
  - LW: MemRead held until dMemReady, then go to WRITEBACK.
  - SW: MemWrite held until dMemReady. In that cycle PCWrite=1, OrigPC=0, then go to FETCH.
  - Timeout rule as in FETCH, with cause 3. The strobe drops the cycle HALT is entered.
- **WRITEBACK.** One cycle, RegWrite=1, then go to FETCH.
  - R / I-ALU: OrigWriteData=1, PCWrite=1, OrigPC=0.
  - LW: OrigWriteData=0, PCWrite=1, OrigPC=0.
  - JAL: OrigWriteData=2, PCWrite=1, OrigPC=2.
  - JALR: OrigWriteData=2, PCWrite=1, OrigPC=3, ALU=ADD.
- **rd==x0.** RegWrite is forced 0 in WRITEBACK; all other behaviour is unchanged.
- **Wait counter.** Cleared on every state change. Counts only in FETCH and MEM.
- **Output timing.** Outputs are Moore-decoded from state plus IR fields, except IRWrite and the SW PCWrite, which also depend on the ready input (Mealy).
- **Latencies (zero wait states).**
  - R / I-ALU / JAL / JALR: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
- **HALT.** All strobes 0, halted=1, haltCause held. Leaves HALT only on resetn.
- **Reset mid-access.** Strobes drop immediately; no partial PC or register write occurs.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- When defined, adds 32-bit outputs cycleCount and instretCount:
  - cycleCount increments every cycle when not in RESET or HALT.
  - instretCount increments on each transition into FETCH from EXECUTE, MEM or WRITEBACK.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined: ports absent, no counter logic.

Decomposition:
- params.v holds:
  - state encodings (RESET, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT)
  - OrigPC values (PC4, PCBEQ, PCIMM, PCALU)
  - OrigWriteData values (ORIG_MEM, ORIG_ALU, ORIG_PC4)
  - ALUControl codes
  - opcode constants
  - haltCause codes
- One combinational sub-module, sequencer_decode: instruction → instruction class, ALUControl, legal flag.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), iMemReady=1 always → IRWrite on cycle 1, RegWrite=1 with OrigWriteData=1 on cycle 4, PCWrite with OrigPC=0.
- LW x5,8(x1), dMemReady delayed 3 cycles → MemRead high 4 cycles, then WRITEBACK with OrigWriteData=0, total 8 cycles.
- BEQ, branchEqual=1 → PCWrite=1, OrigPC=1 in EXECUTE, RegWrite never asserted, back in FETCH at cycle 4.
- Opcode 0x0000007F → halted=1, haltCause=1 after DECODE, no strobes thereafter until resetn.
- iMemReady held 0, MEM_TIMEOUT=16 → iMemRead high 16 cycles, then HALT with cause 2. Separately, resetn pulsed low mid-MEM → MemWrite drops at once, state=RESET.
- ADDI x0,x0,5 → WRITEBACK reached with RegWrite=0. With MULTICYCLE_PERF_EN, instretCount=1 and cycleCount=4 afterwards.
